// File: rtl/hazard_tnew_pipe.sv
// Hazard unit plus the WAG/Tnew/RegWrite tag pipeline (E, M, W) that feeds forwarding select.
// Optional mult/div busy interlock is enabled with `define MULTDIV_BUSY_EN.
module hazard_tnew_pipe
`ifdef MULTDIV_BUSY_EN
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] WAG_D,
  input  logic [1:0] Tnew_D,
  input  logic       RegWrite_D,
`ifdef MULTDIV_BUSY_EN
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       md_busy,
`endif
  output logic [4:0] WAG_E,
  output logic [4:0] WAG_M,
  output logic [4:0] WAG_W,
  output logic [1:0] Tnew_E,
  output logic [1:0] Tnew_M,
  output logic       RegWrite_E,
  output logic       RegWrite_M,
  output logic       RegWrite_W,
  output logic       stall
);

  logic hz_e_rs, hz_e_rt, hz_m_rs, hz_m_rt;
  logic md_stall;

  // A live tag needs a write enable and a non-$0 destination.
  always_comb begin
    hz_e_rs = RegWrite_E & (WAG_E != 5'd0) & (rs_D == WAG_E) & (Tuse_rs_D < Tnew_E);
    hz_e_rt = RegWrite_E & (WAG_E != 5'd0) & (rt_D == WAG_E) & (Tuse_rt_D < Tnew_E);
    hz_m_rs = RegWrite_M & (WAG_M != 5'd0) & (rs_D == WAG_M) & (Tuse_rs_D < Tnew_M);
    hz_m_rt = RegWrite_M & (WAG_M != 5'd0) & (rt_D == WAG_M) & (Tuse_rt_D < Tnew_M);
    stall   = hz_e_rs | hz_e_rt | hz_m_rs | hz_m_rt | md_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WAG_E      <= 5'd0;
      Tnew_E     <= 2'd0;
      RegWrite_E <= 1'b0;
      WAG_M      <= 5'd0;
      Tnew_M     <= 2'd0;
      RegWrite_M <= 1'b0;
      WAG_W      <= 5'd0;
      RegWrite_W <= 1'b0;
    end else begin
      if (stall) begin
        WAG_E      <= 5'd0;
        Tnew_E     <= 2'd0;
        RegWrite_E <= 1'b0;
      end else begin
        WAG_E      <= WAG_D;
        Tnew_E     <= Tnew_D;
        RegWrite_E <= RegWrite_D;
      end
      WAG_M      <= WAG_E;
      Tnew_M     <= (Tnew_E == 2'd0) ? 2'd0 : Tnew_E - 2'd1;
      RegWrite_M <= RegWrite_E;
      WAG_W      <= WAG_M;
      RegWrite_W <= RegWrite_M;
    end
  end

`ifdef MULTDIV_BUSY_EN
  logic [CNT_W-1:0] cnt;
  logic             md_start_E;

  assign md_busy  = (cnt != '0);
  // md_start_E covers the edge where a start has just entered E.
  assign md_stall = md_use_D & (md_busy | md_start_E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      md_start_E <= 1'b0;
    end else begin
      md_start_E <= md_start_D & ~stall;
      if (md_start_D & ~stall)
        cnt <= md_div_D ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end
`else
  assign md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_tnew_pipe.sv
// Directed bench for hazard_tnew_pipe: tag pipeline, Tnew countdown, stall/bubble, reset.
module tb_hazard_tnew_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, WAG_D;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic       RegWrite_D;
  logic [4:0] WAG_E, WAG_M, WAG_W;
  logic [1:0] Tnew_E, Tnew_M;
  logic       RegWrite_E, RegWrite_M, RegWrite_W, stall;
`ifdef MULTDIV_BUSY_EN
  logic md_start_D, md_div_D, md_use_D, md_busy;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_tnew_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
    .WAG_D(WAG_D), .Tnew_D(Tnew_D), .RegWrite_D(RegWrite_D),
`ifdef MULTDIV_BUSY_EN
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D), .md_busy(md_busy),
`endif
    .WAG_E(WAG_E), .WAG_M(WAG_M), .WAG_W(WAG_W), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .stall(stall)
  );

  task automatic set_d(input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt,
                       input logic [4:0] wag, input logic [1:0] tnew, input logic rw);
    rs_D = rs; Tuse_rs_D = trs; rt_D = rt; Tuse_rt_D = trt;
    WAG_D = wag; Tnew_D = tnew; RegWrite_D = rw;
  endtask

  // Inputs change on negedge; outputs sampled 1ns later, clear of the rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    repeat (4) step();
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_d(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    #1;
    tests++;
    if ({WAG_E, WAG_M, WAG_W, Tnew_E, Tnew_M, RegWrite_E, RegWrite_M, RegWrite_W} !== 22'd0) begin
      fails++; $display("FAIL reset_state: got %0h expected 0",
        {WAG_E, WAG_M, WAG_W, Tnew_E, Tnew_M, RegWrite_E, RegWrite_M, RegWrite_W});
    end
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b1);   // lw $8
    #1 chk("lw_no_stall", {7'd0, stall}, 8'd0);
    step();
    chk("lw_in_E_tag", {3'd0, WAG_E}, 8'd8);
    chk("lw_in_E_tnew", {6'd0, Tnew_E}, 8'd2);
    set_d(5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 2'd1, 1'b1);   // addu $9,$8 Tuse=1
    #1 chk("addu_stall", {7'd0, stall}, 8'd1);
    step();
    #1;
    tests++;
    if (WAG_E !== 5'd0 || RegWrite_E !== 1'b0 || Tnew_E !== 2'd0) begin
      fails++; $display("FAIL bubble_E: got wag=%0d rw=%b tnew=%0d expected 0 0 0", WAG_E, RegWrite_E, Tnew_E);
    end
    chk("bubble_M_tag", {3'd0, WAG_M}, 8'd8);
    chk("lw_M_tnew", {6'd0, Tnew_M}, 8'd1);
    chk("addu_release", {7'd0, stall}, 8'd0);
    step();
    chk("addu_in_E", {3'd0, WAG_E}, 8'd9);
  endtask

  task automatic test_branch_two_cycle();
    flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b1);
    step();
    set_d(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);   // beq $8 Tuse=0
    #1 chk("beq_stall_E", {7'd0, stall}, 8'd1);
    step();
    #1 chk("beq_stall_M", {7'd0, stall}, 8'd1);
    step();
    #1 chk("beq_release_W", {7'd0, stall}, 8'd0);
    chk("lw_at_W", {2'd0, RegWrite_W, WAG_W}, 8'h28);
  endtask

  task automatic test_rt_and_tuse_bounds();
    flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd3, 1'b1);   // writer $5 Tnew=3
    step();
    chk("tnew3_E", {6'd0, Tnew_E}, 8'd3);
    set_d(5'd5, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    #1 chk("tuse3_no_stall", {7'd0, stall}, 8'd0);
    Tuse_rs_D = 2'd2;
    #1 chk("tuse2_vs_tnew3", {7'd0, stall}, 8'd1);
    set_d(5'd0, 2'd3, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0);
    #1 chk("rt_hazard_E", {7'd0, stall}, 8'd1);
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    step();
    chk("tnew3_dec_M", {6'd0, Tnew_M}, 8'd2);
    set_d(5'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0);
    #1 chk("rt_hazard_M", {7'd0, stall}, 8'd1);
    Tuse_rt_D = 2'd2;
    #1 chk("rt_M_equal_no_stall", {7'd0, stall}, 8'd0);
    // Tnew=0 saturates at 0 in M
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd0, 1'b1);
    step();
    set_d(5'd6, 2'd0, 5'd6, 2'd0, 5'd0, 2'd0, 1'b0);
    #1 chk("tnew0_E_no_stall", {7'd0, stall}, 8'd0);
    step();
    chk("tnew0_sat_M", {6'd0, Tnew_M}, 8'd0);
  endtask

  task automatic test_zero_and_nowrite();
    flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1, 1'b1);   // addu $0
    step();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    #1 chk("reg0_no_stall", {7'd0, stall}, 8'd0);
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2, 1'b0);   // non-writing $9
    step();
    set_d(5'd9, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0);
    #1 chk("nowrite_no_stall", {7'd0, stall}, 8'd0);
  endtask

  task automatic test_reset_mid_stall();
    flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b1);
    step();
    set_d(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    #1 chk("pre_reset_stall", {7'd0, stall}, 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_clear_E", {RegWrite_E, Tnew_E, WAG_E}, 8'd0);
    chk("async_stall_drop", {7'd0, stall}, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_M", {RegWrite_M, 2'd0, WAG_M}, 8'd0);
  endtask

`ifdef MULTDIV_BUSY_EN
  task automatic test_md_busy();
    int n;
    flush();
    md_start_D = 1'b1; md_div_D = 1'b1; md_use_D = 1'b1;
    #1 chk("div_start_no_stall", {7'd0, stall}, 8'd0);
    step();
    md_start_D = 1'b0; md_div_D = 1'b0;              // mfhi
    n = 0;
    while (md_busy === 1'b1 && n < 20) begin
      #1 chk("mfhi_stall_busy", {7'd0, stall}, 8'd1);
      n++;
      step();
    end
    chk("md_busy_cycles", n[7:0], 8'd10);
    #1 chk("mfhi_release", {7'd0, stall}, 8'd0);
    md_use_D = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b1;
`ifdef MULTDIV_BUSY_EN
    md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0;
`endif
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    test_reset();
    test_load_use();
    test_branch_two_cycle();
    test_rt_and_tuse_bounds();
    test_zero_and_nowrite();
    test_reset_mid_stall();
`ifdef MULTDIV_BUSY_EN
    test_md_busy();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
